// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, sequencer states,
// accumulator-source and memory-address-source encodings.
package cpu_defs_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
    localparam logic [OP_W-1:0] OP_LDA  = 4'h2;
    localparam logic [OP_W-1:0] OP_STA  = 4'h3;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h4;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h5;
    localparam logic [OP_W-1:0] OP_AND  = 4'h6;
    localparam logic [OP_W-1:0] OP_OR   = 4'h7;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h8;
    localparam logic [OP_W-1:0] OP_NOT  = 4'h9;
    localparam logic [OP_W-1:0] OP_JMP  = 4'hA;
    localparam logic [OP_W-1:0] OP_JZ   = 4'hB;
    localparam logic [OP_W-1:0] OP_JC   = 4'hC;
    localparam logic [OP_W-1:0] OP_RSV0 = 4'hD;
    localparam logic [OP_W-1:0] OP_RSV1 = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam logic [1:0] ASRC_ALU = 2'b00;
    localparam logic [1:0] ASRC_IMM = 2'b01;
    localparam logic [1:0] ASRC_MEM = 2'b10;

    localparam logic ADDR_PC   = 1'b0;
    localparam logic ADDR_DATA = 1'b1;

    // ADD..NOT all write the accumulator from the ALU and update flags.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer; the only source of datapath
// load/enable strobes. Strobes are combinational, state and count registered.
module control_unit
    import cpu_defs_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic [3:0]       data_out,
    input  logic             zero_flag,
    input  logic             carry_flag,
    input  logic             mem_ready,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             addr_sel,
    output logic             LoadIR,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_a,
    output logic [1:0]       a_src,
    output logic [3:0]       alu_op,
    output logic             load_flags,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    state_t state;
    state_t state_next;
    logic   exec_done;

    // The operand field feeds the PC/memory datapath directly, not sequencing.
    logic unused_data_out;
    assign unused_data_out = ^data_out;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_FETCH:  if (mem_ready) state_next = ST_DECODE;
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                case (opcode)
                    OP_LDA, OP_STA: if (mem_ready) state_next = ST_FETCH;
                    OP_HLT:         state_next = ST_HALT;
                    default:        state_next = ST_FETCH;
                endcase
            end
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_FETCH;
        endcase
    end

    assign exec_done = (state == ST_EXEC) && (state_next != ST_EXEC);

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clock) begin
        if (reset)          instr_count <= '0;
        else if (exec_done) instr_count <= instr_count + CNT_W'(1);
    end

    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        addr_sel   = ADDR_PC;
        LoadIR     = 1'b0;
        inc_pc     = 1'b0;
        load_pc    = 1'b0;
        load_a     = 1'b0;
        a_src      = ASRC_ALU;
        alu_op     = 4'h0;
        load_flags = 1'b0;
        halted     = (state == ST_HALT);
        if (!reset) begin
            unique case (state)
                ST_FETCH: begin
                    mem_rd = 1'b1;
                    LoadIR = mem_ready;
                    inc_pc = mem_ready;
                end
                ST_EXEC: begin
                    alu_op = opcode;
                    case (opcode)
                        OP_LDI: begin
                            load_a = 1'b1;
                            a_src  = ASRC_IMM;
                        end
                        OP_LDA: begin
                            mem_rd   = 1'b1;
                            addr_sel = ADDR_DATA;
                            load_a   = mem_ready;
                            a_src    = mem_ready ? ASRC_MEM : ASRC_ALU;
                        end
                        OP_STA: begin
                            mem_wr   = 1'b1;
                            addr_sel = ADDR_DATA;
                        end
                        OP_JMP:  load_pc = 1'b1;
                        OP_JZ:   load_pc = zero_flag;
                        OP_JC:   load_pc = carry_flag;
                        default: begin
                            if (is_alu_op(opcode)) begin
                                load_a     = 1'b1;
                                a_src      = ASRC_ALU;
                                load_flags = 1'b1;
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: stimulus queues expected strobes per
// cycle, a negedge monitor pops and compares against two counter widths.
module tb_control_unit;
    import cpu_defs_pkg::*;

    logic        clock;
    logic        reset;
    logic [3:0]  opcode;
    logic [3:0]  data_out;
    logic        zero_flag;
    logic        carry_flag;
    logic        mem_ready;

    logic        mem_rd, mem_wr, addr_sel, LoadIR, inc_pc, load_pc, load_a, load_flags, halted;
    logic [1:0]  a_src;
    logic [3:0]  alu_op;
    logic [15:0] instr_count;

    logic        mem_rd4, mem_wr4, addr_sel4, LoadIR4, inc_pc4, load_pc4, load_a4, load_flags4, halted4;
    logic [1:0]  a_src4;
    logic [3:0]  alu_op4;
    logic [3:0]  instr_count4;

    control_unit #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .data_out(data_out),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel), .LoadIR(LoadIR),
        .inc_pc(inc_pc), .load_pc(load_pc), .load_a(load_a), .a_src(a_src),
        .alu_op(alu_op), .load_flags(load_flags), .halted(halted),
        .instr_count(instr_count)
    );

    control_unit #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .opcode(opcode), .data_out(data_out),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .mem_ready(mem_ready),
        .mem_rd(mem_rd4), .mem_wr(mem_wr4), .addr_sel(addr_sel4), .LoadIR(LoadIR4),
        .inc_pc(inc_pc4), .load_pc(load_pc4), .load_a(load_a4), .a_src(a_src4),
        .alu_op(alu_op4), .load_flags(load_flags4), .halted(halted4),
        .instr_count(instr_count4)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [14:0] strobes;
        int unsigned cnt;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned exp_cnt;
    int unsigned vectors;
    int unsigned miscompares;
    logic [14:0] got;
    logic [14:0] f_wait, f_rdy;

    function automatic logic [14:0] v(input logic rd, input logic wr, input logic as,
                                      input logic ir, input logic inc, input logic lpc,
                                      input logic la, input logic [1:0] src,
                                      input logic [3:0] alu, input logic lf, input logic h);
        return {rd, wr, as, ir, inc, lpc, la, src, alu, lf, h};
    endfunction

    assign got = {mem_rd, mem_wr, addr_sel, LoadIR, inc_pc, load_pc, load_a,
                  a_src, alu_op, load_flags, halted};

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clock) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            vectors++;
            if (got !== mon_e.strobes || instr_count !== 16'(mon_e.cnt) ||
                instr_count4 !== 4'(mon_e.cnt)) begin
                miscompares++;
                $display("FAIL %s: got strobes=%b cnt16=%0d cnt4=%0d, expected strobes=%b cnt16=%0d cnt4=%0d",
                         mon_e.name, got, instr_count, instr_count4,
                         mon_e.strobes, 16'(mon_e.cnt), 4'(mon_e.cnt));
            end
        end
    end

    // One clock cycle: drive inputs, queue expectation, advance past the edge.
    task automatic cyc(input logic r, input logic rdy, input logic [14:0] e,
                       input logic retire, input string nm);
        exp_t x;
        reset     = r;
        mem_ready = rdy;
        x.strobes = e;
        x.cnt     = exp_cnt;
        x.name    = nm;
        sb.push_back(x);
        @(posedge clock);
        #1;
        if (r)           exp_cnt = 0;
        else if (retire) exp_cnt = exp_cnt + 1;
    endtask

    task automatic fetch_decode(input logic [3:0] op, input logic [3:0] d, input string nm);
        opcode   = op;
        data_out = d;
        cyc(1'b0, 1'b1, f_rdy, 1'b0, {nm, "_fetch"});
        cyc(1'b0, 1'b1, 15'd0, 1'b0, {nm, "_decode"});
    endtask

    initial begin
        clock = 1'b0; reset = 1'b1; opcode = 4'h0; data_out = 4'h0;
        zero_flag = 1'b0; carry_flag = 1'b0; mem_ready = 1'b0;
        exp_cnt = 0; vectors = 0; miscompares = 0;
        f_wait = v(1,0,0,0,0,0,0,2'b00,4'h0,0,0);
        f_rdy  = v(1,0,0,1,1,0,0,2'b00,4'h0,0,0);
        repeat (2) @(posedge clock);
        #1;

        cyc(1'b1, 1'b1, 15'd0, 1'b0, "reset_state");

        fetch_decode(OP_LDI, 4'h5, "ldi");
        cyc(1'b0, 1'b0, v(0,0,0,0,0,0,1,2'b01,OP_LDI,0,0), 1'b1, "ldi_exec");

        // LDA with two fetch waits and three operand waits: 8 cycles total.
        opcode = OP_LDA; data_out = 4'h3;
        cyc(1'b0, 1'b0, f_wait, 1'b0, "lda_fwait0");
        cyc(1'b0, 1'b0, f_wait, 1'b0, "lda_fwait1");
        cyc(1'b0, 1'b1, f_rdy,  1'b0, "lda_fetch");
        cyc(1'b0, 1'b1, 15'd0,  1'b0, "lda_decode");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, v(1,0,1,0,0,0,0,2'b00,OP_LDA,0,0), 1'b0, "lda_ewait");
        cyc(1'b0, 1'b1, v(1,0,1,0,0,0,1,2'b10,OP_LDA,0,0), 1'b1, "lda_exec");

        zero_flag = 1'b1;
        fetch_decode(OP_JZ, 4'h9, "jz1");
        cyc(1'b0, 1'b0, v(0,0,0,0,0,1,0,2'b00,OP_JZ,0,0), 1'b1, "jz1_exec");
        zero_flag = 1'b0;
        fetch_decode(OP_JZ, 4'h9, "jz0");
        cyc(1'b0, 1'b0, v(0,0,0,0,0,0,0,2'b00,OP_JZ,0,0), 1'b1, "jz0_exec");

        fetch_decode(OP_ADD, 4'h2, "add");
        cyc(1'b0, 1'b1, v(0,0,0,0,0,0,1,2'b00,OP_ADD,1,0), 1'b1, "add_exec");
        carry_flag = 1'b1;
        fetch_decode(OP_JC, 4'h4, "jc");
        cyc(1'b0, 1'b0, v(0,0,0,0,0,1,0,2'b00,OP_JC,0,0), 1'b1, "jc_exec");
        fetch_decode(OP_JMP, 4'h1, "jmp");
        cyc(1'b0, 1'b0, v(0,0,0,0,0,1,0,2'b00,OP_JMP,0,0), 1'b1, "jmp_exec");
        carry_flag = 1'b0;

        fetch_decode(OP_STA, 4'h7, "sta");
        cyc(1'b0, 1'b1, v(0,1,1,0,0,0,0,2'b00,OP_STA,0,0), 1'b1, "sta_exec");

        // Reset lands in the STA ready cycle: everything quiet, back to FETCH.
        fetch_decode(OP_STA, 4'h7, "star");
        cyc(1'b1, 1'b1, 15'd0, 1'b0, "sta_reset");
        cyc(1'b0, 1'b0, f_wait, 1'b0, "sta_reset_fetch");

        // 16 NOP-class instructions: the 4-bit counter wraps 15 -> 0.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] op;
            op = (i % 3 == 0) ? OP_NOP : ((i % 3 == 1) ? OP_RSV0 : OP_RSV1);
            fetch_decode(op, 4'hF, "nop");
            cyc(1'b0, 1'b1, v(0,0,0,0,0,0,0,2'b00,op,0,0), 1'b1, "nop_exec");
        end

        fetch_decode(OP_HLT, 4'h0, "hlt");
        cyc(1'b0, 1'b0, v(0,0,0,0,0,0,0,2'b00,OP_HLT,0,0), 1'b1, "hlt_exec");
        for (int i = 0; i < 20; i++) begin
            zero_flag  = 1'($urandom_range(0, 1));
            carry_flag = 1'($urandom_range(0, 1));
            cyc(1'b0, 1'($urandom_range(0, 1)), v(0,0,0,0,0,0,0,2'b00,4'h0,0,1), 1'b0, "halt_hold");
        end
        cyc(1'b1, 1'b1, v(0,0,0,0,0,0,0,2'b00,4'h0,0,1), 1'b0, "halt_reset");
        cyc(1'b0, 1'b0, f_wait, 1'b0, "after_halt_fetch");

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
